// File: rtl/fp_normalize.sv
// Normalising stage of the 12-bit linear to 8-bit float converter: takes the magnitude
// of a sample and shifts it left one bit per cycle until bit 10 is set or the exponent reaches zero.
module fp_normalize #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned EXP_W  = 3,
  parameter int unsigned SIG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [SIG_W-1:0]  out_sig,
  output logic              out_fifth
);

  localparam int unsigned MAG_W = DATA_W - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [MAG_W-1:0]   m, m_d;
  logic [EXP_W-1:0]   e, e_d;
  logic               sign, sign_d;
  logic               out_valid_d, out_sign_d, out_fifth_d;
  logic [EXP_W-1:0]   out_exp_d;
  logic [SIG_W-1:0]   out_sig_d;
  logic [DATA_W-1:0]  neg_c;
  logic [MAG_W-1:0]   mag_c;

  assign in_ready = (state == IDLE);

  // Magnitude of the incoming sample; the most negative code saturates to all ones.
  always_comb begin
    neg_c = DATA_W'(~in_data + DATA_W'(1));
    if (!in_data[DATA_W-1]) begin
      mag_c = in_data[MAG_W-1:0];
    end else if (neg_c[DATA_W-1]) begin
      mag_c = '1;
    end else begin
      mag_c = neg_c[MAG_W-1:0];
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    m_d         = m;
    e_d         = e;
    sign_d      = sign;
    out_valid_d = out_valid;
    out_sign_d  = out_sign;
    out_exp_d   = out_exp;
    out_sig_d   = out_sig;
    out_fifth_d = out_fifth;
    case (state)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_data[DATA_W-1];
          m_d     = mag_c;
          e_d     = '1;
          state_d = NORM;
        end
      end
      NORM: begin
        // e == 0 forces exit, so the exponent never wraps.
        if (m[MAG_W-1] || (e == '0)) begin
          out_exp_d   = e;
          out_sig_d   = m[MAG_W-1 -: SIG_W];
          out_fifth_d = m[MAG_W-1-SIG_W];
          out_sign_d  = sign;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          m_d = {m[MAG_W-2:0], 1'b0};
          e_d = e - EXP_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      m         <= '0;
      e         <= '0;
      sign      <= 1'b0;
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_sig   <= '0;
      out_fifth <= 1'b0;
    end else begin
      state     <= state_d;
      m         <= m_d;
      e         <= e_d;
      sign      <= sign_d;
      out_valid <= out_valid_d;
      out_sign  <= out_sign_d;
      out_exp   <= out_exp_d;
      out_sig   <= out_sig_d;
      out_fifth <= out_fifth_d;
    end
  end

endmodule
